// File: rtl/oam_sprite_scan.sv
// oam_sprite_scan: per-line OBJ range scan over OAM with CPU-priority port sharing and a hit FIFO
module oam_sprite_scan #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_HITS   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        hit_valid,
  output logic [6:0]  hit_index,
  input  logic        hit_ready,
  output logic        scan_busy,
  output logic        scan_done,
  output logic        overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0] MAXH = 8'(MAX_HITS);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    line_q, line_d;
  logic [7:0]    hits_q, hits_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          hv_q, hv_d;
  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [6:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic        cpu_own;
  logic [7:0]  obj_y, diff;
  logic [1:0]  mode, shape, size;
  logic [2:0]  lg, lg2;
  logic [8:0]  height;
  logic        obj_hit;
  logic        pop, full, eval, push, last;
  logic [7:0]  hits_nx;

  // CPU wins the port on any cycle it is not being acknowledged; the scanner gets the rest
  always_comb begin
    cpu_own   = cpu_req & ~ack_q;
    ram_addr  = cpu_own ? cpu_addr : {idx_q, 1'b0};
    ram_we    = cpu_own & cpu_we;
    ram_be    = (cpu_own & cpu_we) ? cpu_be : 4'd0;
    ram_wdata = cpu_own ? cpu_wdata : 32'd0;
  end

  // Vertical range test of the attr0/attr1 word currently on the RAM bus
  always_comb begin
    obj_y   = ram_rdata[7:0];
    mode    = ram_rdata[9:8];
    shape   = ram_rdata[15:14];
    size    = ram_rdata[31:30];
    lg      = (shape == 2'd0) ? 3'd3 + {1'b0, size} :
              (shape == 2'd1) ? ((size == 2'd0) ? 3'd3 : 3'd2 + {1'b0, size}) :
              ((size == 2'd0) ? 3'd4 : (size == 2'd3) ? 3'd6 : 3'd5);
    lg2     = lg + {2'b0, mode == 2'b11};
    height  = 9'd1 << lg2;
    diff    = line_q - obj_y;
    obj_hit = !(mode == 2'b10 || shape == 2'b11) && ({1'b0, diff} < height);
  end

  // Scan sequencing, hit FIFO bookkeeping and CPU completion
  always_comb begin
    pop      = hv_q & hit_ready;
    full     = cnt_q == DEPTH;
    eval     = (state_q == S_SCAN) & ~cpu_own & (~full | pop) & ~line_start;
    push     = eval & obj_hit;
    hits_nx  = hits_q + 8'd1;
    last     = eval & ((idx_q == 7'd127) | (push & (hits_nx == MAXH)));
    state_d  = state_q;
    idx_d    = idx_q;
    line_d   = line_q;
    hits_d   = hits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ack_d    = cpu_own;
    rdata_d  = (cpu_own & ~cpu_we) ? ram_rdata : rdata_q;
    if (pop) rd_d = rd_q + 1'b1;
    if (push) begin
      mem_d[wr_q] = idx_q;
      wr_d        = wr_q + 1'b1;
      hits_d      = hits_nx;
      if (hits_nx == MAXH) ovf_d = 1'b1;
    end
    if (eval) idx_d = last ? 7'd0 : idx_q + 7'd1;
    if (last) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
    if (line_start) begin
      state_d = S_SCAN;
      idx_d   = 7'd0;
      hits_d  = 8'd0;
      ovf_d   = 1'b0;
      line_d  = line_y;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end
    hv_d = cnt_d != '0;
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      line_q  <= '0;
      hits_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      hv_q    <= 1'b0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      hits_q  <= hits_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      hv_q    <= hv_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign hit_valid = hv_q;
  assign hit_index = mem_q[rd_q];
  assign scan_busy = state_q == S_SCAN;
  assign scan_done = done_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_oam_sprite_scan.sv
// tb_oam_sprite_scan: directed scenarios checked against a line-level sprite model and RAM model
module tb_oam_sprite_scan;
  localparam int MAXH = 32;
  logic clock = 1'b0, reset = 1'b1;
  logic line_start = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, hit_ready = 1'b0;
  logic [7:0] line_y = '0, cpu_addr = '0;
  logic [3:0] cpu_be = '0;
  logic [31:0] cpu_wdata = '0;
  logic cpu_ack, ram_we, hit_valid, scan_busy, scan_done, overflow;
  logic [31:0] cpu_rdata, ram_wdata, ram_rdata;
  logic [7:0] ram_addr;
  logic [3:0] ram_be;
  logic [6:0] hit_index;

  oam_sprite_scan #(.FIFO_DEPTH(4), .MAX_HITS(MAXH)) dut (
    .clock(clock), .reset(reset), .line_start(line_start), .line_y(line_y),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .hit_valid(hit_valid), .hit_index(hit_index),
    .hit_ready(hit_ready), .scan_busy(scan_busy), .scan_done(scan_done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  logic [31:0] oam [256];
  assign ram_rdata = oam[ram_addr];
  always @(posedge clock)
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) oam[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int tbl [3][4] = '{'{8, 16, 32, 64}, '{8, 8, 16, 32}, '{16, 32, 32, 64}};

  function automatic logic [31:0] mk(int y, int mode, int shape, int size);
    logic [31:0] w = '0;
    w[7:0] = 8'(y);
    w[9:8] = 2'(mode);
    w[15:14] = 2'(shape);
    w[31:30] = 2'(size);
    return w;
  endfunction

  function automatic logic model_hit(logic [31:0] w, int ly);
    int y = int'(w[7:0]);
    int mode = int'(w[9:8]);
    int shape = int'(w[15:14]);
    int size = int'(w[31:30]);
    int h, diff;
    if (mode == 2 || shape == 3) return 1'b0;
    h = tbl[shape][size];
    if (mode == 3) h = h * 2;
    diff = (ly - y + 256) % 256;
    return diff < h;
  endfunction

  int exp_q[$];
  logic exp_ovf = 1'b0, prev_own = 1'b0, own;
  logic [31:0] exp_rdata = '0;
  int pops = 0, dones = 0, last_pop = -1, nh;

  // Cycle-level compare: port ownership, ack/rdata, hit stream order, completion flags
  initial forever begin
    @(negedge clock);
    #4;
    if (reset) begin
      exp_q.delete();
      prev_own = 1'b0;
      exp_rdata = '0;
      exp_ovf = 1'b0;
    end else begin
      chk("cpu_ack", 32'(cpu_ack), 32'(prev_own));
      chk("cpu_rdata", cpu_rdata, exp_rdata);
      own = cpu_req && !prev_own;
      if (own) begin
        chk("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
        chk("ram_we_cpu", 32'(ram_we), 32'(cpu_we));
        chk("ram_be_cpu", 32'(ram_be), cpu_we ? 32'(cpu_be) : 32'd0);
        if (cpu_we) chk("ram_wdata_cpu", ram_wdata, cpu_wdata);
      end else begin
        chk("ram_we_scan", 32'(ram_we), 32'd0);
        chk("ram_addr_even", 32'(ram_addr[0]), 32'd0);
      end
      if (hit_valid && hit_ready) begin
        if (exp_q.size() == 0) chk("hit_extra", 32'(hit_index), 32'hFFFF_FFFF);
        else chk("hit_index", 32'(hit_index), 32'(exp_q.pop_front()));
        pops++;
        last_pop = int'(hit_index);
      end
      if (scan_done) begin
        dones++;
        chk("overflow_at_done", 32'(overflow), 32'(exp_ovf));
        chk("busy_at_done", 32'(scan_busy), 32'd0);
      end
      if (line_start) begin
        exp_q.delete();
        nh = 0;
        for (int i = 0; i < 128; i++)
          if (model_hit(oam[2*i], int'(line_y))) begin
            nh++;
            if (exp_q.size() < MAXH) exp_q.push_back(i);
          end
        exp_ovf = nh >= MAXH;
      end
      if (own && !cpu_we) exp_rdata = oam[cpu_addr];
      prev_own = own;
    end
  end

  task automatic cpu_acc(input logic we, input logic [7:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic keep, output logic [31:0] rd);
    int lat = 0;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = d;
    if (cpu_ack) @(negedge clock);
    do begin
      @(posedge clock); #1; lat++;
    end while (!cpu_ack && lat < 8);
    chk("cpu_latency", 32'(lat), 32'd1);
    rd = cpu_rdata;
    if (!keep) cpu_req = 1'b0;
  endtask

  task automatic ls(input logic [7:0] y);
    @(negedge clock);
    line_start = 1'b1; line_y = y;
    @(posedge clock); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!scan_done && n < 400);
    chk("scan_done_seen", 32'(scan_done), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (hit_valid && n < 300) begin
      @(posedge clock); #1; n++;
    end
    chk("drained", 32'(hit_valid), 32'd0);
    chk("model_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_addr(input logic [7:0] a);
    int n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (ram_addr != a && n < 300);
    chk("reach_addr", 32'(ram_addr), 32'(a));
  endtask

  task automatic check_zero(input string t);
    chk({t, "_ack"}, 32'(cpu_ack), 32'd0);
    chk({t, "_rdata"}, cpu_rdata, 32'd0);
    chk({t, "_raddr"}, 32'(ram_addr), 32'd0);
    chk({t, "_rwe"}, 32'(ram_we), 32'd0);
    chk({t, "_rbe"}, 32'(ram_be), 32'd0);
    chk({t, "_rwdata"}, ram_wdata, 32'd0);
    chk({t, "_hvalid"}, 32'(hit_valid), 32'd0);
    chk({t, "_hindex"}, 32'(hit_index), 32'd0);
    chk({t, "_busy"}, 32'(scan_busy), 32'd0);
    chk({t, "_done"}, 32'(scan_done), 32'd0);
    chk({t, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  logic [31:0] rd;
  int n, p0, d0;
  int ys [3] = '{30, 58, 57};
  int hs [3] = '{1, 0, 1};

  initial begin
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    chk("model_16x16", 32'(model_hit(mk(10, 0, 0, 1), 12)), 32'd1);
    chk("model_8x8_miss", 32'(model_hit(mk(100, 0, 0, 0), 12)), 32'd0);
    chk("model_wrap", 32'(model_hit(mk(250, 0, 0, 1), 2)), 32'd1);
    chk("model_dbl_58", 32'(model_hit(mk(250, 3, 0, 2), 58)), 32'd0);
    chk("model_dbl_57", 32'(model_hit(mk(250, 3, 0, 2), 57)), 32'd1);
    for (int i = 0; i < 128; i++) cpu_acc(1'b1, 8'(2*i), 4'hF, mk(0, 2, 0, 0), 1'b0, rd);
    cpu_acc(1'b1, 8'h83, 4'hF, 32'h0102_0304, 1'b0, rd);

    cpu_acc(1'b1, 8'd0, 4'hF, mk(10, 0, 0, 1), 1'b0, rd);
    cpu_acc(1'b1, 8'd2, 4'hF, mk(100, 0, 0, 0), 1'b0, rd);
    hit_ready = 1'b1;
    p0 = pops;
    ls(8'd12);
    wait_done(n);
    chk("done_latency", 32'(n), 32'd128);
    drain();
    chk("hit_count_line12", 32'(pops - p0), 32'd1);
    chk("hit_idx_line12", 32'(last_pop), 32'd0);

    cpu_acc(1'b1, 8'd0, 4'hF, mk(0, 2, 0, 0), 1'b0, rd);
    cpu_acc(1'b1, 8'd2, 4'hF, mk(0, 2, 0, 0), 1'b0, rd);
    cpu_acc(1'b1, 8'd10, 4'hF, mk(250, 3, 0, 2), 1'b0, rd);
    for (int k = 0; k < 3; k++) begin
      p0 = pops;
      ls(8'(ys[k]));
      wait_done(n);
      drain();
      chk($sformatf("wrap_hits_y%0d", ys[k]), 32'(pops - p0), 32'(hs[k]));
    end
    chk("wrap_last_idx", 32'(last_pop), 32'd5);

    p0 = pops;
    ls(8'd30);
    fork
      wait_done(n);
      begin
        repeat (20) @(posedge clock);
        cpu_acc(1'b1, 8'h81, 4'hF, 32'hAABB_CCDD, 1'b1, rd);
        cpu_acc(1'b1, 8'h81, 4'b0010, 32'h0000_EE00, 1'b1, rd);
        cpu_acc(1'b1, 8'h83, 4'b1000, 32'h7700_0000, 1'b0, rd);
      end
    join
    chk("done_latency_cpu", 32'(n), 32'd131);
    drain();
    chk("hit_count_cpu", 32'(pops - p0), 32'd1);
    cpu_acc(1'b0, 8'h81, 4'h0, 32'd0, 1'b0, rd);
    chk("be_byte1", rd, 32'hAABB_EEDD);
    cpu_acc(1'b0, 8'h83, 4'h0, 32'd0, 1'b0, rd);
    chk("be_byte3", rd, 32'h7702_0304);

    hit_ready = 1'b0;
    for (int i = 0; i < 128; i++) cpu_acc(1'b1, 8'(2*i), 4'hF, mk(0, 0, 0, 3), 1'b0, rd);
    p0 = pops;
    ls(8'd10);
    repeat (30) @(posedge clock);
    #1;
    chk("bp_valid", 32'(hit_valid), 32'd1);
    chk("bp_busy", 32'(scan_busy), 32'd1);
    chk("bp_stall_addr", 32'(ram_addr), 32'd8);
    hit_ready = 1'b1;
    wait_done(n);
    drain();
    chk("ovf_pops", 32'(pops - p0), 32'd32);
    chk("ovf_last", 32'(last_pop), 32'd31);
    chk("ovf_flag", 32'(overflow), 32'd1);

    hit_ready = 1'b0;
    for (int i = 0; i < 128; i++)
      cpu_acc(1'b1, 8'(2*i), 4'hF, (i == 10 || i == 20 || i == 70) ? mk(0, 0, 0, 3) : mk(0, 2, 0, 0), 1'b0, rd);
    d0 = dones;
    p0 = pops;
    ls(8'd5);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    wait_addr(8'd120);
    chk("abort_queued", 32'(hit_valid), 32'd1);
    ls(8'd6);
    chk("abort_flushed", 32'(hit_valid), 32'd0);
    chk("abort_restart", 32'(ram_addr), 32'd0);
    hit_ready = 1'b1;
    wait_done(n);
    drain();
    repeat (3) @(posedge clock);
    chk("abort_dones", 32'(dones - d0), 32'd1);
    chk("abort_pops", 32'(pops - p0), 32'd3);
    chk("abort_last", 32'(last_pop), 32'd70);

    hit_ready = 1'b0;
    ls(8'd5);
    wait_addr(8'd80);
    chk("rst_pre_valid", 32'(hit_valid), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_zero("midrst");
    @(negedge clock);
    reset = 1'b0;
    hit_ready = 1'b1;
    p0 = pops;
    ls(8'd5);
    wait_done(n);
    drain();
    chk("post_rst_pops", 32'(pops - p0), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
